// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the LC-3b memory stage.
// Hits complete in the same cycle; misses optionally write back the victim, then fill.
module l1_dcache #(
    parameter int unsigned NUM_SETS   = 8,
    parameter int unsigned LINE_BYTES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [1:0]                mem_byte_enable,
    input  logic [15:0]               mem_address,
    input  logic [15:0]               mem_wdata,
    output logic [15:0]               mem_rdata,
    output logic                      mem_resp,
    output logic                      pmem_read,
    output logic                      pmem_write,
    output logic [15:0]               pmem_address,
    output logic [LINE_BYTES*8-1:0]   pmem_wdata,
    input  logic [LINE_BYTES*8-1:0]   pmem_rdata,
    input  logic                      pmem_resp
);

    localparam int unsigned LINE_W = LINE_BYTES * 8;
    localparam int unsigned OFF_W  = 4;
    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned TAG_W  = 16 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t                 state;
    logic [NUM_SETS-1:0]    valid;
    logic [NUM_SETS-1:0]    dirty;
    logic [TAG_W-1:0]       tag_arr  [NUM_SETS];
    logic [LINE_W-1:0]      data_arr [NUM_SETS];

    // Miss context captured on leaving IDLE so the refill does not depend on the CPU holding its request
    logic [TAG_W-1:0]       miss_tag;
    logic [IDX_W-1:0]       miss_idx;

    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       req_idx;
    logic [2:0]             word_sel;
    logic                   req;
    logic                   hit;
    logic                   unused_addr_bit;

    assign req_tag         = mem_address[15 -: TAG_W];
    assign req_idx         = mem_address[OFF_W +: IDX_W];
    assign word_sel        = mem_address[3:1];
    assign req             = mem_read | mem_write;
    assign hit             = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign unused_addr_bit = mem_address[0];

    // CPU-side response and pmem strobes decoded from the current state
    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = '0;
        case (state)
            IDLE: begin
                mem_resp = req && hit;
                if (req && hit && mem_read) begin
                    mem_rdata = data_arr[req_idx][{word_sel, 4'b0000} +: 16];
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[miss_idx], miss_idx, 4'b0000};
                pmem_wdata   = data_arr[miss_idx];
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag, miss_idx, 4'b0000};
            end
            default: ;
        endcase
    end

    // Controller state, line metadata and data array updates
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            valid    <= '0;
            dirty    <= '0;
            miss_tag <= '0;
            miss_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        if (mem_write) begin
                            if (mem_byte_enable[0]) begin
                                data_arr[req_idx][{word_sel, 4'b0000} +: 8] <= mem_wdata[7:0];
                            end
                            if (mem_byte_enable[1]) begin
                                data_arr[req_idx][{word_sel, 4'b1000} +: 8] <= mem_wdata[15:8];
                            end
                            if (|mem_byte_enable) begin
                                dirty[req_idx] <= 1'b1;
                            end
                        end
                    end else if (req) begin
                        miss_tag <= req_tag;
                        miss_idx <= req_idx;
                        // An invalid line is never written back even if its dirty bit is stale
                        state    <= (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty[miss_idx] <= 1'b0;
                        state           <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        data_arr[miss_idx] <= pmem_rdata;
                        tag_arr[miss_idx]  <= miss_tag;
                        valid[miss_idx]    <= 1'b1;
                        dirty[miss_idx]    <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: directed scenarios followed by random traffic,
// checked against a set-level cache model and a sparse backing-memory model.
module tb_l1_dcache;

    localparam int unsigned NS = 8;

    logic         clk;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    l1_dcache #(.NUM_SETS(8), .LINE_BYTES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: per-set contents plus backing memory keyed by line number
    logic         mv   [NS];
    logic         md   [NS];
    logic [8:0]   mt   [NS];
    logic [127:0] mdat [NS];
    logic [127:0] bmem [int];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] get_line(input int la);
        if (!bmem.exists(la)) bmem[la] = {$urandom, $urandom, $urandom, $urandom};
        return bmem[la];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NS); i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    // Hold a pmem strobe for lat extra cycles before answering
    task automatic pmem_wait(input int lat, input bit is_write);
        repeat (lat) begin
            @(posedge clk);
            @(negedge clk);
            if (is_write) chk("wb_hold", 128'(pmem_write), 128'(1));
            else          chk("fill_hold", 128'(pmem_read), 128'(1));
        end
    endtask

    // One complete CPU access; entered and left at posedge+1
    task automatic access(input logic rd, input logic wr, input logic [1:0] be,
                          input logic [15:0] addr, input logic [15:0] wd);
        int idx;
        int w;
        int la;
        int old_la;
        logic [8:0] tg;
        logic hit;
        idx = int'(addr[6:4]);
        w   = int'(addr[3:1]);
        tg  = addr[15:7];
        la  = int'(tg) * 8 + idx;
        hit = mv[idx] && (mt[idx] == tg);
        mem_read        = rd;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_address     = addr;
        mem_wdata       = wd;
        @(negedge clk);
        if (!hit) begin
            chk("miss_no_resp", 128'(mem_resp), 128'(0));
            if (mv[idx] && md[idx]) begin
                old_la = int'(mt[idx]) * 8 + idx;
                @(posedge clk);
                @(negedge clk);
                chk("wb_strobe", 128'(pmem_write), 128'(1));
                chk("wb_no_read", 128'(pmem_read), 128'(0));
                chk("wb_addr", 128'(pmem_address), 128'(old_la * 16));
                chk("wb_data", pmem_wdata, mdat[idx]);
                chk("wb_no_resp", 128'(mem_resp), 128'(0));
                pmem_wait(int'($urandom_range(0, 3)), 1'b1);
                pmem_resp = 1'b1;
                @(posedge clk);
                #1;
                pmem_resp = 1'b0;
                bmem[old_la] = mdat[idx];
                md[idx] = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            chk("fill_strobe", 128'(pmem_read), 128'(1));
            chk("fill_no_write", 128'(pmem_write), 128'(0));
            chk("fill_addr", 128'(pmem_address), 128'(la * 16));
            chk("fill_no_resp", 128'(mem_resp), 128'(0));
            pmem_wait(int'($urandom_range(0, 3)), 1'b0);
            pmem_rdata = get_line(la);
            pmem_resp  = 1'b1;
            @(posedge clk);
            #1;
            pmem_resp  = 1'b0;
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            mv[idx]   = 1'b1;
            md[idx]   = 1'b0;
            mt[idx]   = tg;
            mdat[idx] = bmem[la];
            @(negedge clk);
        end
        chk("hit_resp", 128'(mem_resp), 128'(1));
        chk("hit_no_pread", 128'(pmem_read), 128'(0));
        chk("hit_no_pwrite", 128'(pmem_write), 128'(0));
        if (rd && !wr) chk("rd_data", 128'(mem_rdata), 128'(mdat[idx][w*16 +: 16]));
        @(posedge clk);
        #1;
        if (wr) begin
            if (be[0]) mdat[idx][w*16 +: 8]     = wd[7:0];
            if (be[1]) mdat[idx][w*16 + 8 +: 8] = wd[15:8];
            if (be != 2'b00) md[idx] = 1'b1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        logic [127:0] seed_line;
        logic [15:0]  raddr;
        int           op;

        reset           = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_address     = 16'h0000;
        mem_wdata       = 16'h0000;
        pmem_rdata      = '0;
        pmem_resp       = 1'b0;
        model_reset();

        // Reset values
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_resp", 128'(mem_resp), 128'(0));
        chk("rst_pmem_read", 128'(pmem_read), 128'(0));
        chk("rst_pmem_write", 128'(pmem_write), 128'(0));
        chk("rst_mem_rdata", 128'(mem_rdata), 128'(0));
        chk("rst_pmem_addr", 128'(pmem_address), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Cold read miss at 0x0042 with word1 of the line = 0xBEEF
        seed_line = {$urandom, $urandom, $urandom, $urandom};
        seed_line[31:16] = 16'hBEEF;
        bmem[4] = seed_line;
        access(1'b1, 1'b0, 2'b11, 16'h0042, 16'h0000);
        chk("beef_line_installed", 128'(mdat[4][31:16]), 128'(16'hBEEF));

        // Same-line hit, word 2
        access(1'b1, 1'b0, 2'b11, 16'h0044, 16'h0000);

        // Full-word store hit, read back, then conflict eviction writes the line back
        access(1'b0, 1'b1, 2'b11, 16'h0042, 16'h1234);
        access(1'b1, 1'b0, 2'b11, 16'h0042, 16'h0000);
        access(1'b1, 1'b0, 2'b11, 16'h00C2, 16'h0000);
        chk("evicted_word1", 128'(bmem[4][31:16]), 128'(16'h1234));

        // Byte stores into the word holding 0x1234
        access(1'b1, 1'b0, 2'b11, 16'h0042, 16'h0000);
        access(1'b0, 1'b1, 2'b10, 16'h0042, 16'hAB00);
        access(1'b1, 1'b0, 2'b11, 16'h0042, 16'h0000);
        chk("byte_hi_model", 128'(mdat[4][31:16]), 128'(16'hAB34));
        access(1'b0, 1'b1, 2'b01, 16'h0042, 16'h00CD);
        access(1'b1, 1'b0, 2'b11, 16'h0042, 16'h0000);

        // Store with no byte enables leaves data untouched
        access(1'b0, 1'b1, 2'b00, 16'h0042, 16'hFFFF);
        access(1'b1, 1'b0, 2'b11, 16'h0042, 16'h0000);

        // Read and write together behave as a write; eviction must write it back
        access(1'b1, 1'b1, 2'b11, 16'h0044, 16'h5A5A);
        access(1'b1, 1'b0, 2'b11, 16'h00C4, 16'h0000);
        chk("rw_writeback", 128'(bmem[4][47:32]), 128'(16'h5A5A));

        // Stray pmem_resp while idle is ignored
        pmem_resp = 1'b1;
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("idle_resp_no_pread", 128'(pmem_read), 128'(0));
        chk("idle_resp_no_pwrite", 128'(pmem_write), 128'(0));
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 2'b11, 16'h00C4, 16'h0000);

        // Reset in the second cycle of ALLOCATE abandons the fill
        mem_read    = 1'b1;
        mem_address = 16'h0F72;
        @(negedge clk);
        chk("rst_alloc_miss", 128'(mem_resp), 128'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_alloc_c1", 128'(pmem_read), 128'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_alloc_c2", 128'(pmem_read), 128'(1));
        @(posedge clk);
        #1;
        reset    = 1'b0;
        mem_read = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_alloc_pread", 128'(pmem_read), 128'(0));
        chk("rst_alloc_pwrite", 128'(pmem_write), 128'(0));
        chk("rst_alloc_paddr", 128'(pmem_address), 128'(0));
        chk("rst_alloc_resp", 128'(mem_resp), 128'(0));
        @(posedge clk);
        #1;

        // Same address misses again; CPU drops the request mid-fill, line still installs
        mem_read    = 1'b1;
        mem_address = 16'h0F72;
        @(negedge clk);
        chk("drop_miss", 128'(mem_resp), 128'(0));
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(negedge clk);
        chk("drop_fill_strobe", 128'(pmem_read), 128'(1));
        chk("drop_fill_addr", 128'(pmem_address), 128'(16'h0F70));
        pmem_rdata = get_line(int'(16'h0F70) / 16);
        pmem_resp  = 1'b1;
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        mv[7]   = 1'b1;
        md[7]   = 1'b0;
        mt[7]   = 9'(16'h0F72 >> 7);
        mdat[7] = bmem[int'(16'h0F70) / 16];
        @(negedge clk);
        chk("drop_no_resp", 128'(mem_resp), 128'(0));
        chk("drop_idle_pread", 128'(pmem_read), 128'(0));
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 2'b11, 16'h0F72, 16'h0000);

        // Random traffic over four tags per set
        for (int n = 0; n < 250; n++) begin
            raddr = 16'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
                        ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
            op = int'($urandom_range(0, 3));
            access((op <= 1) || (op == 3), (op >= 2), 2'($urandom_range(0, 3)),
                   raddr, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
